mem_cmd_sequencer: RTL and testbench

Upstream driver for the multi-mode memory block. Accepts one command at a time on a valid/ready port and translates it into the memory's Din/mode_in/chip_en/rw/reset stimulus. Stalls on full/empty and returns read data through a single-entry response buffer. Aborts any command blocked for TIMEOUT cycles and reports an error.

---
 rtl/mem_seq_pkg.sv | 45 ++++
 rtl/mem_cmd_sequencer_if.sv | 30 +++
 rtl/mem_rsp_slot.sv | 31 +++
 rtl/mem_cmd_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_mem_cmd_sequencer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory command sequencer.
//   cmd_op_e : host command opcodes carried on cmd_op
//   rw_e     : memory rw strobe encoding
//   state_e  : sequencer FSM states
//   ERR_*    : err_code values
//   MODE_*   : memory mode field shared with the memory block
package mem_seq_pkg;

    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_WRITE   = 2'd1,
        OP_READ    = 2'd2,
        OP_SETMODE = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        RW_IDLE  = 2'd0,
        RW_WRITE = 2'd1,
        RW_READ  = 2'd2
    } rw_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR       = 3'd1,
        S_RD       = 3'd2,
        S_RD_CAP   = 3'd3,
        S_MODE_RST = 3'd4
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BANK     = 2'd1;
    localparam logic [1:0] ERR_TO_FULL  = 2'd2;
    localparam logic [1:0] ERR_TO_EMPTY = 2'd3;

    localparam int         MODE_W       = 3;
    localparam logic [2:0] MODE_DEFAULT = 3'd0;

    localparam logic [1:0] BANK_ILLEGAL = 2'd3;

    // One-hot chip enable for a legal bank index; the illegal bank maps to 0.
    function automatic logic [2:0] bank_onehot(input logic [1:0] bank);
        bank_onehot = 3'b001 << bank;
    endfunction

endpackage

// File: rtl/mem_cmd_sequencer_if.sv
// Host-side bus of the memory command sequencer.
//   cmd_*  : command offer (valid/ready), opcode, bank, write data, mode
//   rsp_*  : read response (valid/ready) with data
//   err_*  : one-cycle error pulse with code
// master = command issuer / response consumer, slave = sequencer.
interface mem_cmd_sequencer_if #(
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [1:0]    cmd_bank;
    logic [DW-1:0] cmd_data;
    logic [2:0]    cmd_mode;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          err_valid;
    logic [1:0]    err_code;

    modport master (
        output cmd_valid, cmd_op, cmd_bank, cmd_data, cmd_mode, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, err_valid, err_code
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_bank, cmd_data, cmd_mode, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, err_valid, err_code
    );
endinterface

// File: rtl/mem_rsp_slot.sv
// Single-entry valid/ready response register.
//   clk, reset           : clock, synchronous active-high reset
//   fill, fill_data      : load a new entry
//   rsp_ready            : consumer takes the entry
//   rsp_valid, rsp_data  : entry state
// A fill and a drain in the same cycle leave the slot full with the new data.
module mem_rsp_slot #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fill,
    input  logic [DW-1:0] fill_data,
    input  logic          rsp_ready,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= fill | (rsp_valid & ~rsp_ready);
            if (fill) begin
                rsp_data <= fill_data;
            end
        end
    end

endmodule

// File: rtl/mem_cmd_sequencer.sv
// Upstream driver for the multi-mode memory block.
//   clk, reset : clock, synchronous active-high reset
//   bus        : host command / response / error bus (slave side)
//   Din, mode_in, chip_en, rw, mem_reset : memory stimulus
//   Dout, full, empty                    : memory status / read data
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | ready for a command
// S_WR       | waiting for full==0, then one write strobe
// S_RD       | waiting for empty==0 and a free response slot, one read strobe
// S_RD_CAP   | memory presents Dout; captured into the response slot
// S_MODE_RST | one-cycle memory reset with the new mode applied
module mem_cmd_sequencer
    import mem_seq_pkg::*;
#(
    parameter int DW      = 32,
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic                clk,
    input  logic                reset,
    mem_cmd_sequencer_if.slave  bus,
    output logic [DW-1:0]       Din,
    output logic [2:0]          mode_in,
    output logic [2:0]          chip_en,
    output logic [1:0]          rw,
    output logic                mem_reset,
    input  logic [DW-1:0]       Dout,
    input  logic                full,
    input  logic                empty
);

    localparam logic [CW-1:0] STALL_LIMIT = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] stall_q, stall_d;
    logic [1:0]    bank_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] din_q;
    logic [2:0]    mode_q;
    logic          err_valid_q;
    logic [1:0]    err_code_q;

    logic          accept;
    logic          mode_load;
    logic          wr_strobe;
    logic          err_set;
    logic [1:0]    err_code_d;
    logic          slot_fill;
    logic          slot_free;
    rw_e           rw_c;
    logic [2:0]    chip_en_c;
    cmd_op_e       op;

    assign op        = cmd_op_e'(bus.cmd_op);
    assign accept    = bus.cmd_valid & bus.cmd_ready;
    assign slot_free = ~bus.rsp_valid | bus.rsp_ready;

    always_comb begin
        state_d    = state_q;
        stall_d    = stall_q;
        rw_c       = RW_IDLE;
        chip_en_c  = 3'b000;
        wr_strobe  = 1'b0;
        mode_load  = 1'b0;
        err_set    = 1'b0;
        err_code_d = ERR_NONE;
        slot_fill  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept && op != OP_NOP) begin
                    if (bus.cmd_bank == BANK_ILLEGAL) begin
                        err_set    = 1'b1;
                        err_code_d = ERR_BANK;
                    end else begin
                        unique case (op)
                            OP_WRITE: begin
                                state_d = S_WR;
                                stall_d = '0;
                            end
                            OP_READ: begin
                                state_d = S_RD;
                                stall_d = '0;
                            end
                            OP_SETMODE: begin
                                state_d   = S_MODE_RST;
                                mode_load = 1'b1;
                            end
                            default: state_d = S_IDLE;
                        endcase
                    end
                end
            end

            S_WR: begin
                if (!full) begin
                    rw_c      = RW_WRITE;
                    chip_en_c = bank_onehot(bank_q);
                    wr_strobe = 1'b1;
                    state_d   = S_IDLE;
                end else if (stall_q == STALL_LIMIT) begin
                    err_set    = 1'b1;
                    err_code_d = ERR_TO_FULL;
                    state_d    = S_IDLE;
                end else begin
                    stall_d = stall_q + CW'(1);
                end
            end

            S_RD: begin
                if (!empty && slot_free) begin
                    rw_c      = RW_READ;
                    chip_en_c = bank_onehot(bank_q);
                    state_d   = S_RD_CAP;
                end else if (empty && stall_q == STALL_LIMIT) begin
                    err_set    = 1'b1;
                    err_code_d = ERR_TO_EMPTY;
                    state_d    = S_IDLE;
                end else if (stall_q != STALL_LIMIT) begin
                    // Saturates so a long slot stall cannot wrap, and a
                    // later empty stall at the limit times out at once.
                    stall_d = stall_q + CW'(1);
                end
            end

            S_RD_CAP: begin
                slot_fill = 1'b1;
                state_d   = S_IDLE;
            end

            S_MODE_RST: begin
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            stall_q     <= '0;
            bank_q      <= '0;
            data_q      <= '0;
            din_q       <= '0;
            mode_q      <= MODE_DEFAULT;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            stall_q     <= stall_d;
            err_valid_q <= err_set;
            err_code_q  <= err_code_d;
            if (accept) begin
                bank_q <= bus.cmd_bank;
                data_q <= bus.cmd_data;
            end
            if (mode_load) begin
                mode_q <= bus.cmd_mode;
            end
            if (wr_strobe) begin
                din_q <= data_q;
            end
        end
    end

    mem_rsp_slot #(.DW(DW)) u_rsp_slot (
        .clk       (clk),
        .reset     (reset),
        .fill      (slot_fill),
        .fill_data (Dout),
        .rsp_ready (bus.rsp_ready),
        .rsp_valid (bus.rsp_valid),
        .rsp_data  (bus.rsp_data)
    );

    // Strobes are gated by reset so a command caught mid-flight never
    // reaches the memory while reset is asserted.
    assign rw        = reset ? RW_IDLE : rw_c;
    assign chip_en   = reset ? 3'b000 : chip_en_c;
    assign Din       = reset ? '0 : (wr_strobe ? data_q : din_q);
    assign mode_in   = mode_q;
    assign mem_reset = reset | (state_q == S_MODE_RST);

    assign bus.cmd_ready = ~reset & (state_q == S_IDLE);
    assign bus.err_valid = err_valid_q;
    assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_mem_cmd_sequencer.sv
module tb_mem_cmd_sequencer;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] Din;
    logic [2:0]    mode_in;
    logic [2:0]    chip_en;
    logic [1:0]    rw;
    logic          mem_reset;
    logic [DW-1:0] Dout;
    logic          full;
    logic          empty;

    mem_cmd_sequencer_if #(.DW(DW)) bus ();

    mem_cmd_sequencer #(.DW(DW), .TIMEOUT(TIMEOUT), .CW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .Din       (Din),
        .mode_in   (mode_in),
        .chip_en   (chip_en),
        .rw        (rw),
        .mem_reset (mem_reset),
        .Dout      (Dout),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] exp_din;
    logic [2:0]    exp_mode;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level expectation: a WRITE/READ blocked for k cycles
    // strobes on cycle k if k < TIMEOUT, otherwise errors after TIMEOUT cycles.
    task automatic run_cmd(input logic [1:0] op, input logic [1:0] bank,
                           input logic [DW-1:0] data, input logic [2:0] mode,
                           input int k, input logic [DW-1:0] rd_val);
        bit         legal;
        bit         timed_out;
        int         blocked;
        logic [2:0] onehot;
        legal     = (bank != 2'd3);
        timed_out = (k >= TIMEOUT);
        blocked   = timed_out ? TIMEOUT : k;
        onehot    = 3'b001 << bank;

        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_bank  = bank;
        bus.cmd_data  = data;
        bus.cmd_mode  = mode;
        full  = (op == 2'd1) && (k > 0);
        empty = (op == 2'd2) && (k > 0);
        #1;
        chk("idle_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = DW'($urandom);
        bus.cmd_mode  = 3'($urandom_range(0, 7));
        #1;

        if (op == 2'd0) begin
            chk("nop_ready", bus.cmd_ready, 1);
            chk("nop_rw", rw, 0);
            chk("nop_err", bus.err_valid, 0);
        end else if (!legal) begin
            chk("bank_err_valid", bus.err_valid, 1);
            chk("bank_err_code", bus.err_code, 1);
            chk("bank_chip_en", chip_en, 0);
            chk("bank_ready", bus.cmd_ready, 1);
        end else if (op == 2'd3) begin
            chk("mode_rst_pulse", mem_reset, 1);
            chk("mode_rst_rw", rw, 0);
            chk("mode_rst_ready", bus.cmd_ready, 0);
            exp_mode = mode;
            tick();
            chk("mode_rst_end", mem_reset, 0);
            chk("mode_rst_back", bus.cmd_ready, 1);
        end else begin
            for (int c = 0; c < blocked; c++) begin
                Dout = DW'($urandom);
                #1;
                chk("stall_rw", rw, 0);
                chk("stall_chip_en", chip_en, 0);
                chk("stall_ready", bus.cmd_ready, 0);
                chk("stall_err", bus.err_valid, 0);
                chk("stall_din", Din, exp_din);
                tick();
            end
            full  = 1'b0;
            empty = 1'b0;
            #1;
            if (timed_out) begin
                chk("to_err_valid", bus.err_valid, 1);
                chk("to_err_code", bus.err_code, (op == 2'd1) ? 2 : 3);
                chk("to_rw", rw, 0);
                chk("to_ready", bus.cmd_ready, 1);
            end else begin
                chk("strobe_rw", rw, op);
                chk("strobe_chip_en", chip_en, onehot);
                chk("strobe_err", bus.err_valid, 0);
                if (op == 2'd1) begin
                    chk("strobe_din", Din, data);
                    exp_din = data;
                    tick();
                    chk("wr_done_rw", rw, 0);
                    chk("wr_done_chip_en", chip_en, 0);
                    chk("wr_done_ready", bus.cmd_ready, 1);
                end else begin
                    tick();
                    Dout = rd_val;
                    #1;
                    chk("cap_rw", rw, 0);
                    chk("cap_ready", bus.cmd_ready, 0);
                    tick();
                    Dout = DW'($urandom);
                    chk("rsp_valid", bus.rsp_valid, 1);
                    chk("rsp_data", bus.rsp_data, rd_val);
                    chk("rd_done_ready", bus.cmd_ready, 1);
                end
            end
        end
        chk("din_hold", Din, exp_din);
        chk("mode_hold", mode_in, exp_mode);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [1:0]    r_op;
    logic [1:0]    r_bank;
    int            r_k;
    logic [DW-1:0] keep;

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_bank  = 2'd0;
        bus.cmd_data  = '0;
        bus.cmd_mode  = 3'd0;
        bus.rsp_ready = 1'b1;
        Dout          = '0;
        full          = 1'b0;
        empty         = 1'b0;
        exp_din       = '0;
        exp_mode      = 3'd0;

        // reset state
        tick();
        tick();
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_mem_reset", mem_reset, 1);
        chk("rst_rw", rw, 0);
        chk("rst_chip_en", chip_en, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_err_valid", bus.err_valid, 0);
        chk("rst_err_code", bus.err_code, 0);
        chk("rst_din", Din, 0);
        chk("rst_mode_in", mode_in, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", bus.cmd_ready, 1);
        chk("post_rst_mem_reset", mem_reset, 0);
        tick();

        // directed commands
        run_cmd(2'd1, 2'd1, 32'hDEADBEEF, 3'd0, 0, '0);
        bus.rsp_ready = 1'b0;
        run_cmd(2'd2, 2'd0, '0, 3'd0, 0, 32'h12345678);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rsp_hold_valid", bus.rsp_valid, 1);
            chk("rsp_hold_data", bus.rsp_data, 32'h12345678);
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("rsp_drained", bus.rsp_valid, 0);

        run_cmd(2'd1, 2'd2, 32'hA5A5_0001, 3'd0, TIMEOUT, '0);
        run_cmd(2'd1, 2'd0, 32'hA5A5_0002, 3'd0, 5, '0);
        run_cmd(2'd1, 2'd1, 32'hA5A5_0003, 3'd0, TIMEOUT - 1, '0);
        run_cmd(2'd2, 2'd2, '0, 3'd0, TIMEOUT, 32'hBAD0_BAD0);
        run_cmd(2'd2, 2'd1, '0, 3'd0, TIMEOUT - 1, 32'hCAFE_0011);
        run_cmd(2'd3, 2'd0, '0, 3'b101, 0, '0);
        tick();
        chk("mode_stays", mode_in, 5);
        run_cmd(2'd1, 2'd3, 32'h1111_2222, 3'd0, 0, '0);
        run_cmd(2'd0, 2'd2, 32'h3333_4444, 3'd0, 0, '0);

        // response-slot stall never times out
        bus.rsp_ready = 1'b0;
        run_cmd(2'd2, 2'd2, '0, 3'd0, 0, 32'h0BAD_F00D);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd2;
        bus.cmd_bank  = 2'd2;
        tick();
        bus.cmd_valid = 1'b0;
        for (int c = 0; c < TIMEOUT + 4; c++) begin
            chk("slot_stall_rw", rw, 0);
            chk("slot_stall_err", bus.err_valid, 0);
            chk("slot_stall_data", bus.rsp_data, 32'h0BAD_F00D);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("slot_strobe_rw", rw, 2);
        chk("slot_strobe_chip_en", chip_en, 3'b100);
        tick();
        Dout = 32'h7777_8888;
        #1;
        chk("slot_cap_valid", bus.rsp_valid, 0);
        tick();
        chk("slot_rsp_valid", bus.rsp_valid, 1);
        chk("slot_rsp_data", bus.rsp_data, 32'h7777_8888);
        tick();
        chk("slot_rsp_drain", bus.rsp_valid, 0);

        // reset while a read is stalled, with a response pending
        bus.rsp_ready = 1'b0;
        run_cmd(2'd2, 2'd1, '0, 3'd0, 0, 32'h5555_6666);
        empty         = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd2;
        bus.cmd_bank  = 2'd0;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        empty = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_rw", rw, 0);
        chk("mid_rst_chip_en", chip_en, 0);
        chk("mid_rst_mem_reset", mem_reset, 1);
        chk("mid_rst_ready", bus.cmd_ready, 0);
        tick();
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        chk("mid_rst_rsp_data", bus.rsp_data, 0);
        chk("mid_rst_din", Din, 0);
        chk("mid_rst_mode_in", mode_in, 0);
        chk("mid_rst_err", bus.err_valid, 0);
        exp_din  = '0;
        exp_mode = 3'd0;
        reset         = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        chk("after_rst_ready", bus.cmd_ready, 1);
        chk("after_rst_rw", rw, 0);
        tick();
        chk("after_rst_no_strobe", rw, 0);
        chk("after_rst_idle", bus.cmd_ready, 1);

        // randomized commands
        for (int i = 0; i < 40; i++) begin
            r_op   = 2'($urandom_range(0, 3));
            r_bank = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_k    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2))
                                                 : int'($urandom_range(0, 4));
            keep   = DW'($urandom);
            run_cmd(r_op, r_bank, keep, 3'($urandom_range(0, 7)), r_k, DW'($urandom));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
